// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage between the EX/MEM and MEM/WB buffers.
// It owns the data memory and the stack pointer. Single-word load, store,
// push and pop complete in one cycle. 32-bit PC push/pop takes two cycles
// and stalls upstream for the first one. Popped flags go back to the ALU.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   alu_result, read_data*  address / data sources from EX/MEM
//   PC, pc_plus_one         32-bit PC values for CALL/INT pushes
//   flag_register           flags for a flags push
//   mem_* / *_select        memory operation controls
//   passthrough inputs      copied to the matching *_out registers
//   stall                   combinational; holds EX/MEM during a two-word op
//   mem_data_out            word read by a load or pop
//   pc_from_memory          PC popped by RET/RTI, valid with pc_choose_memory_out
//   conditions_from_memory_pop  popped flags, valid with flags_restore
module memory_stage #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] alu_result,
    input  logic [15:0] read_data1,
    input  logic [15:0] read_data2,
    input  logic [31:0] PC,
    input  logic [31:0] pc_plus_one,
    input  logic [2:0]  flag_register,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_push,
    input  logic        mem_pop,
    input  logic [1:0]  memory_address_select,
    input  logic [1:0]  memory_write_src_select,
    input  logic        pc_choose_memory,
    input  logic        reg_write,
    input  logic        outport_enable,
    input  logic        inPortSelect,
    input  logic [1:0]  wb_sel,
    input  logic [2:0]  reg_write_address,
    input  logic [15:0] LDM_value,
    input  logic [15:0] inPortValue,
    output logic        stall,
    output logic [15:0] mem_data_out,
    output logic [15:0] result_out,
    output logic [15:0] LDM_value_out,
    output logic [15:0] inPortValue_out,
    output logic        reg_write_out,
    output logic        outport_enable_out,
    output logic        inPortSelect_out,
    output logic [1:0]  wb_sel_out,
    output logic [2:0]  reg_write_address_out,
    output logic [31:0] pc_from_memory,
    output logic        pc_choose_memory_out,
    output logic [2:0]  conditions_from_memory_pop,
    output logic        flags_restore
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_PUSH2, S_POP2} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [15:0]       pop_low_q, pop_low_d;
    logic [15:0]       mem [DEPTH];

    logic [15:0] mem_data_out_d, result_out_d, ldm_d, inport_d;
    logic        reg_write_d, outport_enable_d, inport_sel_d;
    logic [1:0]  wb_sel_d;
    logic [2:0]  reg_waddr_d;
    logic [31:0] pc_from_memory_d;
    logic        pc_choose_d, flags_restore_d;
    logic [2:0]  cond_d;

    logic              idle, wide_src, pc_pop_start, push_start;
    logic [15:0]       sel_addr, wr_word;
    logic [31:0]       src32;
    logic [ADDR_W-1:0] plain_addr, sp_inc, sp_dec, rd_addr, waddr;
    logic              we;
    logic [15:0]       wdata, rd_data;
    logic              unused_bits;

    assign unused_bits = ^read_data2[15:ADDR_W];

    // Decode of the operation presented in IDLE
    assign idle         = (state_q == S_IDLE);
    assign wide_src     = (memory_write_src_select == 2'b01) || (memory_write_src_select == 2'b10);
    assign pc_pop_start = idle & mem_pop & pc_choose_memory;
    assign push_start   = idle & mem_push & ~mem_pop & wide_src;

    assign sel_addr   = (memory_address_select == 2'b01) ? read_data2 : alu_result;
    assign plain_addr = sel_addr[ADDR_W-1:0];
    assign sp_inc     = sp_q + ADDR_W'(1);
    assign sp_dec     = sp_q - ADDR_W'(1);
    assign src32      = (memory_write_src_select == 2'b01) ? pc_plus_one : PC;

    // Write word: the high half only on the first cycle of a 32-bit push
    always_comb begin
        wr_word = read_data1;
        case (memory_write_src_select)
            2'b00:   wr_word = read_data1;
            2'b11:   wr_word = {13'b0, flag_register};
            default: wr_word = (idle & mem_push) ? src32[31:16] : src32[15:0];
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pc_pop_start)    state_d = S_POP2;
                else if (push_start) state_d = S_PUSH2;
            end
            S_PUSH2: state_d = S_IDLE;
            S_POP2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: stall plus memory/stack-pointer control
    always_comb begin
        stall   = ~reset & (pc_pop_start | push_start);
        rd_addr = plain_addr;
        we      = 1'b0;
        waddr   = plain_addr;
        wdata   = wr_word;
        sp_d    = sp_q;
        case (state_q)
            S_IDLE: begin
                if (mem_pop) begin
                    rd_addr = sp_inc;
                    sp_d    = sp_inc;
                end else if (mem_push) begin
                    we    = 1'b1;
                    waddr = sp_q;
                    sp_d  = sp_dec;
                end else if (mem_write) begin
                    we = 1'b1;
                end
            end
            S_PUSH2: begin
                we    = 1'b1;
                waddr = sp_q;
                sp_d  = sp_dec;
            end
            S_POP2: begin
                rd_addr = sp_inc;
                sp_d    = sp_inc;
            end
            default: ;
        endcase
        // Reset aborts a pending second word
        if (reset) we = 1'b0;
    end

    // Combinational read returns pre-write data on a same-cycle write
    assign rd_data = mem[rd_addr];

    // MEM/WB buffer next values; first cycle of a two-word op is a bubble
    always_comb begin
        mem_data_out_d   = mem_data_out;
        result_out_d     = alu_result;
        ldm_d            = LDM_value;
        inport_d         = inPortValue;
        reg_write_d      = reg_write & ~stall;
        outport_enable_d = outport_enable & ~stall;
        inport_sel_d     = inPortSelect;
        wb_sel_d         = wb_sel;
        reg_waddr_d      = reg_write_address;
        pc_from_memory_d = pc_from_memory;
        pc_choose_d      = 1'b0;
        cond_d           = conditions_from_memory_pop;
        flags_restore_d  = 1'b0;
        pop_low_d        = pop_low_q;
        if ((idle & (mem_read | mem_pop)) | (state_q == S_POP2))
            mem_data_out_d = rd_data;
        if (idle & mem_pop) begin
            if (pc_choose_memory) begin
                pop_low_d = rd_data;
            end else if (memory_write_src_select == 2'b11) begin
                cond_d          = rd_data[2:0];
                flags_restore_d = 1'b1;
            end
        end
        if (state_q == S_POP2) begin
            pc_from_memory_d = {rd_data, pop_low_q};
            pc_choose_d      = 1'b1;
        end
    end

    // Data memory: not cleared by reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // State, stack pointer and MEM/WB registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                    <= S_IDLE;
            sp_q                       <= '1;
            pop_low_q                  <= '0;
            mem_data_out               <= '0;
            result_out                 <= '0;
            LDM_value_out              <= '0;
            inPortValue_out            <= '0;
            reg_write_out              <= 1'b0;
            outport_enable_out         <= 1'b0;
            inPortSelect_out           <= 1'b0;
            wb_sel_out                 <= '0;
            reg_write_address_out      <= '0;
            pc_from_memory             <= '0;
            pc_choose_memory_out       <= 1'b0;
            conditions_from_memory_pop <= '0;
            flags_restore              <= 1'b0;
        end else begin
            state_q                    <= state_d;
            sp_q                       <= sp_d;
            pop_low_q                  <= pop_low_d;
            mem_data_out               <= mem_data_out_d;
            result_out                 <= result_out_d;
            LDM_value_out              <= ldm_d;
            inPortValue_out            <= inport_d;
            reg_write_out              <= reg_write_d;
            outport_enable_out         <= outport_enable_d;
            inPortSelect_out           <= inport_sel_d;
            wb_sel_out                 <= wb_sel_d;
            reg_write_address_out      <= reg_waddr_d;
            pc_from_memory             <= pc_from_memory_d;
            pc_choose_memory_out       <= pc_choose_d;
            conditions_from_memory_pop <= cond_d;
            flags_restore              <= flags_restore_d;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] alu_result, read_data1, read_data2, LDM_value, inPortValue;
    logic [31:0] PC, pc_plus_one;
    logic [2:0]  flag_register, reg_write_address;
    logic        mem_read, mem_write, mem_push, mem_pop, pc_choose_memory;
    logic [1:0]  memory_address_select, memory_write_src_select, wb_sel;
    logic        reg_write, outport_enable, inPortSelect;
    logic        stall, reg_write_out, outport_enable_out, inPortSelect_out;
    logic [15:0] mem_data_out, result_out, LDM_value_out, inPortValue_out;
    logic [1:0]  wb_sel_out;
    logic [2:0]  reg_write_address_out, conditions_from_memory_pop;
    logic [31:0] pc_from_memory;
    logic        pc_choose_memory_out, flags_restore;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: flat word memory and a wrapping stack pointer
    logic [15:0] ref_mem [DEPTH];
    int          ref_sp;

    memory_stage #(.ADDR_W(11)) dut (
        .clk(clk), .reset(reset), .alu_result(alu_result), .read_data1(read_data1),
        .read_data2(read_data2), .PC(PC), .pc_plus_one(pc_plus_one),
        .flag_register(flag_register), .mem_read(mem_read), .mem_write(mem_write),
        .mem_push(mem_push), .mem_pop(mem_pop), .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select), .pc_choose_memory(pc_choose_memory),
        .reg_write(reg_write), .outport_enable(outport_enable), .inPortSelect(inPortSelect),
        .wb_sel(wb_sel), .reg_write_address(reg_write_address), .LDM_value(LDM_value),
        .inPortValue(inPortValue), .stall(stall), .mem_data_out(mem_data_out),
        .result_out(result_out), .LDM_value_out(LDM_value_out), .inPortValue_out(inPortValue_out),
        .reg_write_out(reg_write_out), .outport_enable_out(outport_enable_out),
        .inPortSelect_out(inPortSelect_out), .wb_sel_out(wb_sel_out),
        .reg_write_address_out(reg_write_address_out), .pc_from_memory(pc_from_memory),
        .pc_choose_memory_out(pc_choose_memory_out),
        .conditions_from_memory_pop(conditions_from_memory_pop), .flags_restore(flags_restore)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        alu_result = '0; read_data1 = '0; read_data2 = '0; PC = '0; pc_plus_one = '0;
        flag_register = '0; mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
        memory_address_select = '0; memory_write_src_select = '0; pc_choose_memory = 0;
        reg_write = 0; outport_enable = 0; inPortSelect = 0; wb_sel = '0;
        reg_write_address = '0; LDM_value = '0; inPortValue = '0;
    endtask

    task automatic ref_push(input logic [15:0] w);
        ref_mem[ref_sp] = w;
        ref_sp = (ref_sp + DEPTH - 1) % DEPTH;
    endtask

    task automatic ref_pop(output logic [15:0] w);
        ref_sp = (ref_sp + 1) % DEPTH;
        w = ref_mem[ref_sp];
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1;
        tick();
        reset = 0;
        ref_sp = DEPTH - 1;
    endtask

    task automatic test_reset();
        logic [127:0] outs;
        reset = 1; set_idle(); tick();
        reset = 0;
        reg_write = 1; outport_enable = 1; inPortSelect = 1; wb_sel = 2'b11;
        reg_write_address = 3'h7; alu_result = 16'hFFFF; LDM_value = 16'hAAAA; inPortValue = 16'h5555;
        tick();
        reset = 1; tick();
        reset = 0; set_idle(); #1;
        outs = {mem_data_out, result_out, LDM_value_out, inPortValue_out, reg_write_out,
                outport_enable_out, inPortSelect_out, wb_sel_out, reg_write_address_out,
                pc_from_memory, pc_choose_memory_out, conditions_from_memory_pop, flags_restore};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++;
        if (dut.sp_q !== 11'h7FF) begin n_fail++; $display("FAIL reset_sp: got %h expected 7ff", dut.sp_q); end
        ref_sp = DEPTH - 1;
    endtask

    task automatic test_push_pop();
        do_reset();
        read_data1 = 16'hBEEF; mem_push = 1; #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL push_stall: got %b expected 0", stall); end
        tick();
        n_checks++;
        if (dut.sp_q !== 11'h7FE) begin n_fail++; $display("FAIL push_sp: got %h expected 7fe", dut.sp_q); end
        set_idle(); mem_pop = 1;
        tick();
        n_checks++;
        if (mem_data_out !== 16'hBEEF) begin n_fail++; $display("FAIL pop_data: got %h expected beef", mem_data_out); end
        n_checks++;
        if (dut.sp_q !== 11'h7FF) begin n_fail++; $display("FAIL pop_sp: got %h expected 7ff", dut.sp_q); end
        set_idle();
    endtask

    task automatic test_call_ret();
        do_reset();
        pc_plus_one = 32'h0001_2345; memory_write_src_select = 2'b01; mem_push = 1; reg_write = 1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL call_stall1: got %b expected 1", stall); end
        tick();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL call_stall2: got %b expected 0", stall); end
        n_checks++;
        if (reg_write_out !== 1'b0) begin n_fail++; $display("FAIL call_bubble: got %b expected 0", reg_write_out); end
        tick();
        n_checks++;
        if (dut.sp_q !== 11'h7FD) begin n_fail++; $display("FAIL call_sp: got %h expected 7fd", dut.sp_q); end
        set_idle(); mem_pop = 1; pc_choose_memory = 1; #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL ret_stall: got %b expected 1", stall); end
        tick();
        n_checks++;
        if (pc_choose_memory_out !== 1'b0) begin n_fail++; $display("FAIL ret_early_valid: got %b expected 0", pc_choose_memory_out); end
        tick();
        n_checks++;
        if (pc_from_memory !== 32'h0001_2345) begin n_fail++; $display("FAIL ret_pc: got %h expected 00012345", pc_from_memory); end
        n_checks++;
        if (pc_choose_memory_out !== 1'b1) begin n_fail++; $display("FAIL ret_valid: got %b expected 1", pc_choose_memory_out); end
        set_idle(); tick();
        n_checks++;
        if (pc_choose_memory_out !== 1'b0) begin n_fail++; $display("FAIL ret_pulse: got %b expected 0", pc_choose_memory_out); end
        n_checks++;
        if (dut.sp_q !== 11'h7FF) begin n_fail++; $display("FAIL ret_sp: got %h expected 7ff", dut.sp_q); end
        // Stack words checked through plain loads
        memory_address_select = 2'b01; read_data2 = 16'h07FF; mem_read = 1; tick();
        n_checks++;
        if (mem_data_out !== 16'h0001) begin n_fail++; $display("FAIL call_hi_word: got %h expected 0001", mem_data_out); end
        read_data2 = 16'h07FE; tick();
        n_checks++;
        if (mem_data_out !== 16'h2345) begin n_fail++; $display("FAIL call_lo_word: got %h expected 2345", mem_data_out); end
        set_idle();
    endtask

    task automatic test_std_ldd();
        set_idle(); alu_result = 16'h0010; read_data1 = 16'h1234; mem_write = 1; tick();
        set_idle(); memory_address_select = 2'b01; read_data2 = 16'h0010; alu_result = 16'h0555;
        mem_read = 1; tick();
        n_checks++;
        if (mem_data_out !== 16'h1234) begin n_fail++; $display("FAIL ldd: got %h expected 1234", mem_data_out); end
        set_idle(); alu_result = 16'h0010; read_data1 = 16'h9999; mem_write = 1; mem_read = 1; tick();
        n_checks++;
        if (mem_data_out !== 16'h1234) begin n_fail++; $display("FAIL read_before_write: got %h expected 1234", mem_data_out); end
        set_idle(); alu_result = 16'h0010; mem_read = 1; tick();
        n_checks++;
        if (mem_data_out !== 16'h9999) begin n_fail++; $display("FAIL ldd_after_write: got %h expected 9999", mem_data_out); end
        set_idle();
    endtask

    task automatic test_wrap_flags();
        do_reset();
        alu_result = 16'h0000; read_data1 = 16'h0BAD; mem_write = 1; tick();
        set_idle(); mem_pop = 1; tick();
        n_checks++;
        if (mem_data_out !== 16'h0BAD) begin n_fail++; $display("FAIL wrap_pop_data: got %h expected 0bad", mem_data_out); end
        n_checks++;
        if (dut.sp_q !== 11'h000) begin n_fail++; $display("FAIL wrap_pop_sp: got %h expected 000", dut.sp_q); end
        set_idle(); mem_push = 1; read_data1 = 16'h1357; tick();
        n_checks++;
        if (dut.sp_q !== 11'h7FF) begin n_fail++; $display("FAIL wrap_push_sp: got %h expected 7ff", dut.sp_q); end
        set_idle(); alu_result = 16'hF800; mem_read = 1; tick();
        n_checks++;
        if (mem_data_out !== 16'h1357) begin n_fail++; $display("FAIL wrap_push_data: got %h expected 1357", mem_data_out); end
        set_idle(); mem_push = 1; memory_write_src_select = 2'b11; flag_register = 3'b101; tick();
        set_idle(); mem_pop = 1; memory_write_src_select = 2'b11; tick();
        n_checks++;
        if (conditions_from_memory_pop !== 3'b101) begin n_fail++; $display("FAIL flags_pop: got %b expected 101", conditions_from_memory_pop); end
        n_checks++;
        if (flags_restore !== 1'b1) begin n_fail++; $display("FAIL flags_restore: got %b expected 1", flags_restore); end
        set_idle(); tick();
        n_checks++;
        if (flags_restore !== 1'b0) begin n_fail++; $display("FAIL flags_pulse: got %b expected 0", flags_restore); end
        set_idle();
    endtask

    task automatic test_reset_in_push2();
        do_reset();
        alu_result = 16'h07FE; read_data1 = 16'hA5A5; mem_write = 1; tick();
        set_idle(); PC = 32'hCAFE_F00D; memory_write_src_select = 2'b10; mem_push = 1; tick();
        reset = 1; #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL push2_reset_stall: got %b expected 0", stall); end
        tick();
        reset = 0; set_idle(); #1;
        n_checks++;
        if (dut.sp_q !== 11'h7FF) begin n_fail++; $display("FAIL push2_reset_sp: got %h expected 7ff", dut.sp_q); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL push2_reset_idle: got %b expected 0", stall); end
        alu_result = 16'h07FE; mem_read = 1; tick();
        n_checks++;
        if (mem_data_out !== 16'hA5A5) begin n_fail++; $display("FAIL push2_low_unwritten: got %h expected a5a5", mem_data_out); end
        alu_result = 16'h07FF; tick();
        n_checks++;
        if (mem_data_out !== 16'hCAFE) begin n_fail++; $display("FAIL push2_high_written: got %h expected cafe", mem_data_out); end
        set_idle();
    endtask

    task automatic test_random();
        int depth, op;
        int addrs[$];
        logic [15:0] w, lo, hi, a;
        logic [31:0] w32;
        logic        rw;
        logic [1:0]  wbs;
        logic [2:0]  rwa;
        do_reset();
        depth = 0;
        for (int it = 0; it < 400; it++) begin
            set_idle();
            rw = 1'($urandom); wbs = 2'($urandom); rwa = 3'($urandom);
            op = $urandom_range(0, 7);
            if ((op == 2 || op == 3) && depth < 1) op = 0;
            if (op == 7 && depth < 2) op = 6;
            if ((op == 0 || op == 1 || op == 6) && depth > 60) op = 7;
            if (op == 5 && addrs.size() == 0) op = 4;
            if (op >= 6) rw = 1'b1;
            reg_write = rw; wb_sel = wbs; reg_write_address = rwa;
            alu_result = 16'($urandom); LDM_value = 16'($urandom);
            case (op)
                0: begin
                    read_data1 = 16'($urandom); mem_push = 1;
                    ref_push(read_data1); depth++;
                end
                1: begin
                    flag_register = 3'($urandom); mem_push = 1; memory_write_src_select = 2'b11;
                    ref_push({13'b0, flag_register}); depth++;
                end
                2: begin mem_pop = 1; ref_pop(w); depth--; end
                3: begin mem_pop = 1; memory_write_src_select = 2'b11; ref_pop(w); depth--; end
                4: begin
                    a = 16'($urandom_range(0, 1023));
                    alu_result = {5'($urandom), a[10:0]};
                    memory_address_select = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b10 + 2'($urandom_range(0, 1));
                    mem_write = 1;
                    if ($urandom_range(0, 1) != 0) begin
                        read_data1 = 16'($urandom); w = read_data1;
                    end else begin
                        pc_plus_one = $urandom; memory_write_src_select = 2'b01; w = pc_plus_one[15:0];
                    end
                    ref_mem[a] = w; addrs.push_back(int'(a));
                end
                5: begin
                    a = 16'(addrs[$urandom_range(0, addrs.size() - 1)]);
                    read_data2 = {5'($urandom), a[10:0]}; memory_address_select = 2'b01; mem_read = 1;
                    w = ref_mem[a];
                end
                6: begin
                    w32 = $urandom; mem_push = 1;
                    if ($urandom_range(0, 1) != 0) begin pc_plus_one = w32; memory_write_src_select = 2'b01; end
                    else begin PC = w32; memory_write_src_select = 2'b10; end
                    ref_push(w32[31:16]); ref_push(w32[15:0]); depth += 2;
                end
                default: begin
                    mem_pop = 1; pc_choose_memory = 1;
                    ref_pop(lo); ref_pop(hi); depth -= 2;
                end
            endcase
            #1;
            n_checks++;
            if (stall !== (op >= 6)) begin n_fail++; $display("FAIL rnd_stall op%0d: got %b expected %b", op, stall, op >= 6); end
            if (op >= 6) begin
                tick();
                n_checks++;
                if (reg_write_out !== 1'b0) begin n_fail++; $display("FAIL rnd_bubble op%0d: got %b expected 0", op, reg_write_out); end
            end
            tick();
            n_checks++;
            if (dut.sp_q !== 11'(ref_sp)) begin n_fail++; $display("FAIL rnd_sp op%0d: got %h expected %h", op, dut.sp_q, 11'(ref_sp)); end
            n_checks++;
            if ({result_out, reg_write_out, wb_sel_out, reg_write_address_out} !== {alu_result, rw, wbs, rwa}) begin
                n_fail++;
                $display("FAIL rnd_passthrough op%0d: got %h expected %h", op,
                         {result_out, reg_write_out, wb_sel_out, reg_write_address_out}, {alu_result, rw, wbs, rwa});
            end
            n_checks++;
            if (flags_restore !== (op == 3) || pc_choose_memory_out !== (op == 7)) begin
                n_fail++;
                $display("FAIL rnd_pulses op%0d: got %b%b expected %b%b", op, flags_restore, pc_choose_memory_out, op == 3, op == 7);
            end
            if (op == 2 || op == 5) begin
                n_checks++;
                if (mem_data_out !== w) begin n_fail++; $display("FAIL rnd_read op%0d: got %h expected %h", op, mem_data_out, w); end
            end
            if (op == 3) begin
                n_checks++;
                if (conditions_from_memory_pop !== w[2:0]) begin n_fail++; $display("FAIL rnd_flags: got %b expected %b", conditions_from_memory_pop, w[2:0]); end
            end
            if (op == 7) begin
                n_checks++;
                if (pc_from_memory !== {hi, lo}) begin n_fail++; $display("FAIL rnd_ret_pc: got %h expected %h", pc_from_memory, {hi, lo}); end
            end
        end
        set_idle();
    endtask

    initial begin
        reset = 1;
        set_idle();
        ref_sp = DEPTH - 1;
        test_reset();
        test_push_pop();
        test_call_ret();
        test_std_ldd();
        test_wrap_flags();
        test_reset_in_push2();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
